// File: rtl/mem_pkg.sv
// Shared types and default sizing for the shared-memory arbiter.
package mem_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 15;

    // IDLE  | waiting for any request, latches the winner's command
    // ISSUE | mem_valid high for one cycle with the latched command
    // WAIT  | waiting for mem_ready or for the timeout to expire
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin winner selection: first requester at or after rr_ptr,
// scanning upward and wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_ptr, k)]) begin
                grant = wrap_add(rr_ptr, k);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory command port among NREQ requesters.
// One transaction at a time: latch in IDLE, strobe in ISSUE, complete in WAIT
// on mem_ready or after TIMEOUT WAIT cycles (error completion).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NREQ       = DEF_NREQ,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_wr_rd,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]      req_wdata,
    output logic [NREQ-1:0]            done,
    output logic                       err,
    output logic [WIDTH-1:0]           rsp_rdata,
    output logic                       mem_valid,
    output logic                       mem_wr_rd,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [WIDTH-1:0]           mem_wdata,
    input  logic [WIDTH-1:0]           mem_rdata,
    input  logic                       mem_ready
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NREQ-1:0]         done_q, done_d;
    logic                    err_q, err_d;
    logic [WIDTH-1:0]        rdata_q, rdata_d;

    logic [IDX_W-1:0]        grant;
    logic                    any;
    logic [IDX_W-1:0]        next_ptr;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (grant),
        .any    (any)
    );

    // Pointer moves just past the requester being completed.
    assign next_ptr = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    // Next-state and command/response updates; only IDLE samples requester inputs.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        wr_rd_d  = wr_rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    idx_d   = grant;
                    wr_rd_d = req_wr_rd[grant];
                    addr_d  = req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[grant*WIDTH +: WIDTH];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    done_d[idx_q] = 1'b1;
                    if (!wr_rd_q) begin
                        rdata_d = mem_rdata;
                    end
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th WAIT cycle without an acknowledge.
                    done_d[idx_q] = 1'b1;
                    err_d         = 1'b1;
                    rr_ptr_d      = next_ptr;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            wr_rd_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            wr_rd_q  <= wr_rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign rsp_rdata = rdata_q;
    assign mem_valid = (state_q == ISSUE);
    assign mem_wr_rd = wr_rd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for arbitration order, reset abort, latched-command
// stability and stray acknowledges.
module tb_mem_arbiter;

    localparam int W  = 8;
    localparam int AW = 4;
    localparam int NR = 4;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR-1:0]   req_wr_rd;
    logic [NR*AW-1:0] req_addr;
    logic [NR*W-1:0] req_wdata;
    logic [NR-1:0]   done;
    logic            err;
    logic [W-1:0]    rsp_rdata;
    logic            mem_valid;
    logic            mem_wr_rd;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [W-1:0]    mem_rdata;
    logic            mem_ready;

    logic            ready_en;
    logic            stray_ready;
    logic            mem_ready_m;
    logic [W-1:0]    mem [16] = '{3: 8'hA5, default: 8'h00};

    int n_vec;
    int n_miss;

    mem_arbiter #(
        .WIDTH      (W),
        .DEPTH      (16),
        .ADDR_WIDTH (AW),
        .NREQ       (NR),
        .TIMEOUT    (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr_rd (req_wr_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rsp_rdata (rsp_rdata),
        .mem_valid (mem_valid),
        .mem_wr_rd (mem_wr_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acknowledges one cycle after the strobe when enabled.
    always @(posedge clk) begin
        mem_ready_m <= mem_valid & ready_en;
        if (mem_valid && ready_en) begin
            if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
            else           mem_rdata <= mem[mem_addr];
        end
    end
    assign mem_ready = mem_ready_m | stray_ready;

    typedef struct {
        int          who;
        logic        wr;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic        rdy;
        logic [3:0]  exp_done;
        logic        exp_err;
        logic [7:0]  exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int who, input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                          output int lat, output logic [3:0] d, output logic e, output int nvalid);
        @(negedge clk);
        req_wr_rd[who]         = wr;
        req_addr[who*AW +: AW] = addr;
        req_wdata[who*W +: W]  = wdata;
        req[who]               = 1'b1;
        lat = 0; d = '0; e = 1'b0; nvalid = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_valid) nvalid++;
            if (done != '0) begin
                lat = k; d = done; e = err;
                break;
            end
        end
        req[who] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, nvalid, n_ev;
        logic [3:0]  d;
        logic        e;
        int          ev_k [5];
        logic [3:0]  ev_d [5];
        logic [3:0]  exp_order [5];

        n_vec = 0; n_miss = 0;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        vecs[0] = '{1, 1'b0, 4'd3, 8'hFF, 1'b1, 4'b0010, 1'b0, 8'hA5, 3};
        vecs[1] = '{0, 1'b1, 4'd5, 8'h3C, 1'b1, 4'b0001, 1'b0, 8'hA5, 3};
        vecs[2] = '{2, 1'b0, 4'd5, 8'hFF, 1'b1, 4'b0100, 1'b0, 8'h3C, 3};
        vecs[3] = '{3, 1'b1, 4'd7, 8'h5A, 1'b1, 4'b1000, 1'b0, 8'h3C, 3};
        vecs[4] = '{3, 1'b0, 4'd7, 8'h00, 1'b1, 4'b1000, 1'b0, 8'h5A, 3};
        vecs[5] = '{0, 1'b0, 4'd3, 8'h00, 1'b0, 4'b0001, 1'b1, 8'h5A, 17};
        vecs[6] = '{1, 1'b1, 4'd9, 8'h77, 1'b0, 4'b0010, 1'b1, 8'h5A, 17};
        vecs[7] = '{2, 1'b0, 4'd9, 8'h00, 1'b1, 4'b0100, 1'b0, 8'h00, 3};
        vecs[8] = '{0, 1'b0, 4'd3, 8'h00, 1'b1, 4'b0001, 1'b0, 8'hA5, 3};

        rst = 1'b1; req = '0; req_wr_rd = '0; req_addr = '0; req_wdata = '0;
        ready_en = 1'b1; stray_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done",  32'(done), 32'h0);
        check("rst_err",   32'(err), 32'h0);
        check("rst_valid", 32'(mem_valid), 32'h0);
        check("rst_wr_rd", 32'(mem_wr_rd), 32'h0);
        check("rst_addr",  32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_rdata", 32'(rsp_rdata), 32'h0);
        rst = 1'b0;

        // Single-requester transactions from the table.
        for (int i = 0; i < 9; i++) begin
            ready_en = vecs[i].rdy;
            do_txn(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, d, e, nvalid);
            check($sformatf("v%0d_done", i),   32'(d), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_err", i),    32'(e), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata", i),  32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("v%0d_lat", i),    32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_addr", i),   32'(mem_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d_wr_rd", i),  32'(mem_wr_rd), 32'(vecs[i].wr));
            check($sformatf("v%0d_nvalid", i), 32'(nvalid), 32'd1);
        end

        // Command inputs changing during WAIT must not disturb the latched command.
        ready_en = 1'b0;
        @(negedge clk);
        req_wr_rd[2] = 1'b1; req_addr[2*AW +: AW] = 4'd6; req_wdata[2*W +: W] = 8'h11; req[2] = 1'b1;
        repeat (2) @(negedge clk);
        req_wr_rd[2] = 1'b0; req_addr[2*AW +: AW] = 4'hC; req_wdata[2*W +: W] = 8'hEE;
        @(negedge clk);
        check("hold_addr",  32'(mem_addr), 32'h6);
        check("hold_wdata", 32'(mem_wdata), 32'h11);
        check("hold_wr_rd", 32'(mem_wr_rd), 32'h1);
        d = '0; e = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done != '0) begin d = done; e = err; break; end
        end
        req[2] = 1'b0;
        check("hold_done",     32'(d), 32'b0100);
        check("hold_err",      32'(e), 32'h1);
        check("hold_addr_end", 32'(mem_addr), 32'h6);

        // Reset during WAIT aborts silently and returns the pointer to 0.
        @(negedge clk);
        req_wr_rd[1] = 1'b0; req_addr[1*AW +: AW] = 4'd2; req_wdata[1*W +: W] = 8'h66; req[1] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        check("abort_done",  32'(done), 32'h0);
        check("abort_err",   32'(err), 32'h0);
        check("abort_valid", 32'(mem_valid), 32'h0);
        check("abort_addr",  32'(mem_addr), 32'h0);
        check("abort_wdata", 32'(mem_wdata), 32'h0);
        check("abort_rdata", 32'(rsp_rdata), 32'h0);
        rst = 1'b0; ready_en = 1'b1;
        req_wr_rd = '0; req[0] = 1'b1; req[3] = 1'b1;
        n_ev = 0; ev_d[0] = '0; ev_d[1] = '0;
        for (int k = 0; k < 20 && n_ev < 2; k++) begin
            @(negedge clk);
            if (done != '0) begin ev_d[n_ev] = done; n_ev++; end
        end
        req = '0;
        check("ptr0_first",  32'(ev_d[0]), 32'b0001);
        check("ptr0_second", 32'(ev_d[1]), 32'b1000);

        // All four requesting from reset: strict rotation, one grant per 3 cycles.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin ev_k[i] = -1; ev_d[i] = '0; end
        n_ev = 0;
        for (int k = 1; k <= 30 && n_ev < 5; k++) begin
            @(negedge clk);
            if (done != '0) begin ev_k[n_ev] = k; ev_d[n_ev] = done; n_ev++; end
        end
        req = '0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr%0d_done", i), 32'(ev_d[i]), 32'(exp_order[i]));
            check($sformatf("rr%0d_cycle", i), 32'(ev_k[i]), 32'(3 * (i + 1)));
        end

        // Acknowledges outside WAIT are ignored.
        @(negedge clk);
        stray_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stray_idle%0d", k), 32'(done), 32'h0);
        end
        ready_en = 1'b0;
        req_wr_rd[1] = 1'b0; req_addr[1*AW +: AW] = 4'd3; req[1] = 1'b1;
        lat = 0; d = '0; e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) stray_ready = 1'b0;
            if (done != '0) begin lat = k; d = done; e = err; break; end
        end
        req = '0;
        check("stray_issue_done", 32'(d), 32'b0010);
        check("stray_issue_err",  32'(e), 32'h1);
        check("stray_issue_lat",  32'(lat), 32'd17);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the shared memory port.
REQ-002 SHALL have parameter DEPTH, default 16, word count of the shared memory.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), memory address width.
REQ-004 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-005 SHALL have parameter TIMEOUT, default 15, max WAIT cycles before error completion.
REQ-006 clk  input  1  clock, all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 req  input  NREQ  per-requester request level, held until matching done pulse.
REQ-009 req_wr_rd  input  NREQ  per-requester op: 1=write, 0=read.
REQ-010 req_addr  input  NREQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-011 req_wdata  input  NREQ*WIDTH  packed write data, requester i at slice i.
REQ-012 done  output  NREQ  one-cycle completion pulse, one-hot or zero.
REQ-013 err  output  1  one-cycle pulse with done when completion was by timeout.
REQ-014 rsp_rdata  output  WIDTH  read data of most recent successful read.
REQ-015 mem_valid / mem_wr_rd  output  1 each  memory command strobe and op.
REQ-016 mem_addr / mem_wdata  output  ADDR_WIDTH / WIDTH  memory command address and data.
REQ-017 mem_rdata / mem_ready  input  WIDTH / 1  memory read data and one-cycle-late acknowledge.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-019 IDLE: any req bit high -> latch winner index, op, addr, wdata; go ISSUE; else stay.
REQ-020 Winner SHALL be first requester at or after rr_ptr, ascending, wrapping NREQ-1 -> 0.
REQ-021 ISSUE: mem_valid=1 with latched command for exactly one cycle; go WAIT.
REQ-022 mem_valid SHALL be 0 in IDLE and WAIT; mem_addr/mem_wdata/mem_wr_rd hold latched values.
REQ-023 WAIT: mem_ready=1 -> next cycle done[winner]=1, err=0; go IDLE.
REQ-024 On read completion rsp_rdata SHALL capture mem_rdata in the same edge done is set; writes leave rsp_rdata unchanged.
REQ-025 WAIT timeout counter SHALL clear on entry; reaching TIMEOUT without mem_ready -> done[winner]=1, err=1, rsp_rdata unchanged; go IDLE.
REQ-026 On any completion rr_ptr SHALL become (winner+1) mod NREQ.
REQ-027 Latency: req seen in IDLE at cycle 0 -> mem_valid cycle 1 -> mem_ready cycle 2 -> done cycle 3; back-to-back grants every 3 cycles.
REQ-028 Requests arriving or dropping during ISSUE/WAIT SHALL NOT alter the latched command.
REQ-029 mem_ready outside WAIT SHALL be ignored.
REQ-030 All NREQ requesting simultaneously SHALL each be served exactly once per NREQ grants.

Reset
REQ-031 rst SHALL force state IDLE, rr_ptr=0, timeout counter=0, done=0, err=0, mem_valid=0, mem_wr_rd=0, mem_addr=0, mem_wdata=0, rsp_rdata=0.
REQ-032 rst mid-transaction SHALL abort without a done pulse; requester re-requests.

Structure
REQ-033 Shared package mem_pkg SHALL hold state enum (IDLE/ISSUE/WAIT) and default WIDTH/DEPTH constants.
REQ-034 Winner selection SHALL be a sub-module rr_pick (req, rr_ptr -> grant index, any).

Verification
REQ-035 Single read: mem[3]=8'hA5 preloaded, req[1] read addr 3 -> done[1] at cycle 3, rsp_rdata=8'hA5, err=0.
REQ-036 Write then read: req[0] write addr 5 data 8'h3C, then req[2] read addr 5 -> rsp_rdata=8'h3C.
REQ-037 All four req high from reset -> done order 0,1,2,3,0, spacing 3 cycles.
REQ-038 mem_ready tied 0 -> done[winner] and err pulse after TIMEOUT=15 WAIT cycles, rsp_rdata unchanged.
REQ-039 rst asserted during WAIT -> no done, all outputs 0 next cycle, rr_ptr=0.
REQ-040 req[2] write addr changed during WAIT -> mem_addr keeps originally latched address.
